// File: rtl/seq1100_pkg.sv
// Shared encoding and transition rules for the time-multiplexed "1100" detector.
// The engine is Moore and non-overlapping: after a match it restarts from scratch.
package seq1100_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S11   = 3'd2,
        S110  = 3'd3,
        S1100 = 3'd4
    } state_e;

    function automatic state_e next_state(input state_e state, input logic b);
        state_e nxt;
        nxt = IDLE;
        case (state)
            IDLE:    nxt = b ? S1  : IDLE;
            S1:      nxt = b ? S11 : IDLE;
            S11:     nxt = b ? S11 : S110;
            S110:    nxt = b ? S1  : S1100;
            S1100:   nxt = b ? S1  : IDLE;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

    function automatic logic is_hit(input state_e nxt);
        return (nxt == S1100);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, wrapping, skipping masked channels.
// The pointer moves to one past the winner and holds when nothing is granted.
module rr_arbiter #(
    parameter int NCH = 4,
    localparam int IW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en_i,
    input  logic [NCH-1:0] req_i,
    input  logic [NCH-1:0] mask_i,
    output logic [NCH-1:0] grant_o,
    output logic           grant_vld_o,
    output logic [IW-1:0]  grant_idx_o
);

    logic [IW-1:0]  ptr_q;
    logic [IW-1:0]  ptr_d;
    logic [NCH-1:0] eligible;

    always_comb begin
        int            p;
        logic [IW-1:0] p_idx;
        p           = 0;
        p_idx       = '0;
        eligible    = req_i & ~mask_i & {NCH{en_i}};
        grant_vld_o = 1'b0;
        grant_idx_o = '0;
        for (int i = 0; i < NCH; i++) begin
            p = int'(ptr_q) + i;
            if (p >= NCH) p = p - NCH;
            p_idx = IW'(p);
            if (!grant_vld_o && eligible[p_idx]) begin
                grant_vld_o = 1'b1;
                grant_idx_o = p_idx;
            end
        end
        grant_o = grant_vld_o ? (NCH'(1) << grant_idx_o) : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld_o) begin
            ptr_d = (grant_idx_o == IW'(NCH - 1)) ? '0 : grant_idx_o + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/seq1100_rr_sched.sv
// One shared "1100" engine serving NCH serial channels in round-robin order, with
// per-channel saved state and saturating match counters readable by index.
module seq1100_rr_sched
    import seq1100_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 8,
    localparam int IW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [NCH-1:0] bit_vld,
    input  logic [NCH-1:0] bit_in,
    output logic [NCH-1:0] bit_rdy,
    input  logic           clr_ch_vld,
    input  logic [IW-1:0]  clr_ch,
    output logic           det_vld,
    output logic [IW-1:0]  det_ch,
    output logic           det_hit,
    input  logic [IW-1:0]  rd_ch,
    output logic [CW-1:0]  rd_cnt
);

    // Handshake: bit c is consumed on a rising edge where bit_vld[c] && bit_rdy[c].
    // bit_rdy never looks at bit_in, so a source may change its data freely while waiting.

    state_e         state_q [NCH];
    logic [CW-1:0]  cnt_q   [NCH];
    logic           det_vld_q;
    logic [IW-1:0]  det_ch_q;
    logic           det_hit_q;

    logic [NCH-1:0] clr_mask;
    logic [NCH-1:0] grant;
    logic           gnt_vld;
    logic [IW-1:0]  gnt_idx;
    state_e         gnt_next;

    // Out-of-range clear indices match no channel and so do nothing.
    always_comb begin
        clr_mask = '0;
        if (clr_ch_vld) begin
            for (int c = 0; c < NCH; c++) begin
                if (clr_ch == IW'(c)) clr_mask[c] = 1'b1;
            end
        end
    end

    rr_arbiter #(.NCH(NCH)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en & ~rst),
        .req_i       (bit_vld),
        .mask_i      (clr_mask),
        .grant_o     (grant),
        .grant_vld_o (gnt_vld),
        .grant_idx_o (gnt_idx)
    );

    assign bit_rdy = grant;

    always_comb begin
        gnt_next = IDLE;
        for (int c = 0; c < NCH; c++) begin
            if (gnt_idx == IW'(c)) gnt_next = next_state(state_q[c], bit_in[c]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                state_q[c] <= IDLE;
                cnt_q[c]   <= '0;
            end
            det_vld_q <= 1'b0;
            det_ch_q  <= '0;
            det_hit_q <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (clr_mask[c]) begin
                    state_q[c] <= IDLE;
                    cnt_q[c]   <= '0;
                end else if (grant[c]) begin
                    state_q[c] <= gnt_next;
                    if (is_hit(gnt_next) && (cnt_q[c] != {CW{1'b1}})) begin
                        cnt_q[c] <= cnt_q[c] + CW'(1);
                    end
                end
            end
            det_vld_q <= gnt_vld;
            det_ch_q  <= gnt_idx;
            det_hit_q <= gnt_vld && is_hit(gnt_next);
        end
    end

    assign det_vld = det_vld_q;
    assign det_ch  = det_ch_q;
    assign det_hit = det_hit_q;

    // Reads see registered counts only; an update in flight shows up next cycle.
    always_comb begin
        rd_cnt = '0;
        for (int c = 0; c < NCH; c++) begin
            if (rd_ch == IW'(c)) rd_cnt = cnt_q[c];
        end
    end

endmodule

// File: tb/tb_seq1100_rr_sched.sv
// Directed bench for seq1100_rr_sched: a default instance plus a CW=2 instance for saturation.
module tb_seq1100_rr_sched;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] bit_vld;
    logic [3:0] bit_in;
    logic [3:0] bit_rdy;
    logic       clr_ch_vld;
    logic [1:0] clr_ch;
    logic       det_vld;
    logic [1:0] det_ch;
    logic       det_hit;
    logic [1:0] rd_ch;
    logic [7:0] rd_cnt;

    logic       en2;
    logic [3:0] vld2;
    logic [3:0] bin2;
    logic [3:0] rdy2;
    logic       clr_vld2;
    logic [1:0] clr_ch2;
    logic       dv2;
    logic [1:0] dch2;
    logic       dhit2;
    logic [1:0] rd_ch2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    seq1100_rr_sched #(.NCH(4), .CW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bit_vld    (bit_vld),
        .bit_in     (bit_in),
        .bit_rdy    (bit_rdy),
        .clr_ch_vld (clr_ch_vld),
        .clr_ch     (clr_ch),
        .det_vld    (det_vld),
        .det_ch     (det_ch),
        .det_hit    (det_hit),
        .rd_ch      (rd_ch),
        .rd_cnt     (rd_cnt)
    );

    seq1100_rr_sched #(.NCH(4), .CW(2)) dut_cw2 (
        .clk        (clk),
        .rst        (rst),
        .en         (en2),
        .bit_vld    (vld2),
        .bit_in     (bin2),
        .bit_rdy    (rdy2),
        .clr_ch_vld (clr_vld2),
        .clr_ch     (clr_ch2),
        .det_vld    (dv2),
        .det_ch     (dch2),
        .det_hit    (dhit2),
        .rd_ch      (rd_ch2),
        .rd_cnt     (cnt2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle on the main instance: drive, check grant, clock, check detect outputs.
    task automatic step(input logic [3:0] vld, input logic [3:0] bits,
                        input logic cv, input logic [1:0] cc,
                        input logic [3:0] exp_rdy, input logic exp_dv,
                        input logic [1:0] exp_ch, input logic exp_hit, input string tag);
        bit_vld    = vld;
        bit_in     = bits;
        clr_ch_vld = cv;
        clr_ch     = cc;
        #1 check({tag, ".bit_rdy"}, 32'(bit_rdy), 32'(exp_rdy));
        @(posedge clk);
        #1;
        check({tag, ".det_vld"}, 32'(det_vld), 32'(exp_dv));
        check({tag, ".det_hit"}, 32'(det_hit), 32'(exp_hit));
        if (exp_dv) check({tag, ".det_ch"}, 32'(det_ch), 32'(exp_ch));
        bit_vld    = '0;
        clr_ch_vld = 1'b0;
    endtask

    task automatic check_cnt(input logic [1:0] ch, input logic [7:0] exp, input string tag);
        rd_ch = ch;
        #1 check(tag, 32'(rd_cnt), 32'(exp));
    endtask

    task automatic do_reset(input string tag);
        rst     = 1'b1;
        bit_vld = 4'hF;
        bit_in  = 4'hF;
        #1 check({tag, ".rdy_in_rst"}, 32'(bit_rdy), 32'h0);
        @(posedge clk);
        #1;
        check({tag, ".det_vld"}, 32'(det_vld), 32'h0);
        check({tag, ".det_hit"}, 32'(det_hit), 32'h0);
        check({tag, ".det_ch"},  32'(det_ch),  32'h0);
        rst     = 1'b0;
        bit_vld = '0;
        bit_in  = '0;
    endtask

    task automatic step2(input logic b, input logic exp_hit, input string tag);
        vld2 = 4'b0100;
        bin2 = {1'b0, b, 2'b00};
        #1 check({tag, ".rdy"}, 32'(rdy2), 32'h4);
        @(posedge clk);
        #1 check({tag, ".hit"}, 32'(dhit2), 32'(exp_hit));
        vld2 = '0;
    endtask

    initial begin
        logic [7:0] seq8;
        logic [7:0] hit8;
        logic [3:0] pat;
        logic       b;
        logic [1:0] sat_exp [5];

        rst = 1'b1; en = 1'b1; bit_vld = '0; bit_in = '0;
        clr_ch_vld = 1'b0; clr_ch = '0; rd_ch = '0;
        en2 = 1'b0; vld2 = '0; bin2 = '0; clr_vld2 = 1'b0; clr_ch2 = '0; rd_ch2 = 2'd2;
        @(posedge clk);
        #1;

        // Reset state
        do_reset("reset");
        check_cnt(2'd0, 8'd0, "reset.cnt0");
        check_cnt(2'd3, 8'd0, "reset.cnt3");

        // Ch0 alone: 1,1,0,0 hits on the 4th bit
        step(4'b0001, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 1'b0, "t1.b1");
        step(4'b0001, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 1'b0, "t1.b2");
        step(4'b0001, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 1'b0, "t1.b3");
        step(4'b0001, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 1'b1, "t1.b4");
        check_cnt(2'd0, 8'd1, "t1.cnt0");

        // Clear ch0 with nothing valid: no grant, count back to 0
        step(4'b0000, 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 2'd0, 1'b0, "clr0");
        check_cnt(2'd0, 8'd0, "clr0.cnt0");

        // Ch0 1,1,1,0,0,1,0,0: single hit at bit 5 (non-overlapping)
        seq8 = 8'b1110_0100;
        hit8 = 8'b0000_1000;
        for (int i = 7; i >= 0; i--) begin
            step(4'b0001, {3'b000, seq8[i]}, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, hit8[i],
                 $sformatf("t2.b%0d", 8 - i));
        end
        check_cnt(2'd0, 8'd1, "t2.cnt0");

        // Reset after 1,1,0 discards progress and the pending detect
        step(4'b0001, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 1'b0, "t6.b1");
        step(4'b0001, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 1'b0, "t6.b2");
        step(4'b0001, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 1'b0, "t6.b3");
        do_reset("t6.rst");
        check_cnt(2'd0, 8'd0, "t6.cnt0");
        step(4'b0001, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 1'b0, "t6.lone0");
        step(4'b0001, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 1'b0, "t6.c1");
        step(4'b0001, 4'b0001, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 1'b0, "t6.c2");
        step(4'b0001, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 1'b0, "t6.c3");
        step(4'b0001, 4'b0000, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd0, 1'b1, "t6.c4");
        check_cnt(2'd0, 8'd1, "t6.cnt0");
        do_reset("t3.rst");

        // All four valid: grants rotate 0..3, each channel sees 1,1,0,0
        pat = 4'b1100;
        for (int k = 0; k < 16; k++) begin
            b = pat[3 - k / 4];
            step(4'hF, {4{b}}, 1'b0, 2'd0, 4'(1 << (k % 4)), 1'b1, 2'(k % 4), (k >= 12),
                 $sformatf("t3.k%0d", k));
        end
        for (int c = 0; c < 4; c++) check_cnt(2'(c), 8'd1, $sformatf("t3.cnt%0d", c));

        // Ch1 to S110, then clear it while valid; grant passes to ch2
        step(4'b0010, 4'b0010, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 1'b0, "t4.b1");
        step(4'b0010, 4'b0010, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 1'b0, "t4.b2");
        step(4'b0010, 4'b0000, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 1'b0, "t4.b3");
        step(4'b0110, 4'b0000, 1'b1, 2'd1, 4'b0100, 1'b1, 2'd2, 1'b0, "t4.clr");
        check_cnt(2'd1, 8'd0, "t4.cnt1");
        check_cnt(2'd2, 8'd1, "t4.cnt2");
        step(4'b0010, 4'b0000, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 1'b0, "t4.after0");
        step(4'b0010, 4'b0010, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 1'b0, "t4.c1");
        step(4'b0010, 4'b0010, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 1'b0, "t4.c2");
        step(4'b0010, 4'b0000, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 1'b0, "t4.c3");
        step(4'b0010, 4'b0000, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 1'b1, "t4.c4");
        check_cnt(2'd1, 8'd1, "t4.cnt1b");

        // en=0 blocks all grants
        en = 1'b0;
        step(4'hF, 4'hF, 1'b0, 2'd0, 4'b0000, 1'b0, 2'd0, 1'b0, "en0");
        en = 1'b1;

        // CW=2 instance: ch2 fed 1100 five times, counter saturates at 3
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
        en2 = 1'b1;
        for (int r = 0; r < 5; r++) begin
            step2(1'b1, 1'b0, $sformatf("t5.r%0d.b1", r));
            step2(1'b1, 1'b0, $sformatf("t5.r%0d.b2", r));
            step2(1'b0, 1'b0, $sformatf("t5.r%0d.b3", r));
            step2(1'b0, 1'b1, $sformatf("t5.r%0d.b4", r));
            check($sformatf("t5.r%0d.cnt", r), 32'(cnt2), 32'(sat_exp[r]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq1100_rr_sched.md
Name: seq1100_rr_sched

Overview:
- Time-multiplexes one Moore "1100" detection engine (non-overlapping) across NCH serial bit channels.
- A round-robin arbiter grants one channel per cycle; the engine loads that channel's saved state, advances it by one bit, writes it back, and reports the result.
- Keeps a saturating match counter per channel, readable by channel index.
- Sits between the serial front-ends and the status/CSR logic.

Parameters:
- NCH, 4, number of serial channels (2..16).
- CW, 8, width of each per-channel match counter.
- IW, $clog2(NCH), channel index width (derived, not overridden).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable; when 0, no grants are issued.
- bit_vld  input  NCH  per-channel bit valid.
- bit_in  input  NCH  per-channel serial bit.
- bit_rdy  output  NCH  per-channel grant; combinational; one-hot or zero.
- clr_ch_vld  input  1  request to clear one channel.
- clr_ch  input  IW  channel to clear.
- det_vld  output  1  registered; a bit was processed in the previous cycle.
- det_ch  output  IW  registered; channel of that bit.
- det_hit  output  1  registered; that bit completed 1100.
- rd_ch  input  IW  counter read select.
- rd_cnt  output  CW  combinational read of the selected counter.

Behaviour:
- Reset values:
  - All channel states are IDLE and all counters are 0.
  - RR pointer is 0.
  - det_vld, det_ch and det_hit are 0.
  - bit_rdy is 0 while rst is high.
- Handshake:
  - A bit is consumed when bit_vld[c] and bit_rdy[c] are both 1.
  - bit_rdy[c] depends only on en, bit_vld, the pointer and the clear request, never on bit_in.
- Arbitration:
  - The grant goes to the first channel with bit_vld=1, searching from ptr upward and wrapping at NCH-1 to 0.
  - After a grant to channel g, ptr becomes (g+1) mod NCH.
  - With no grant, ptr holds.
  - en=0 forces bit_rdy=0 and ptr holds.
- Engine states (3-bit, stored per channel), transitions on the consumed bit:
  - IDLE: 1->S1, 0->IDLE
  - S1: 1->S11, 0->IDLE
  - S11: 1->S11, 0->S110
  - S110: 1->S1, 0->S1100
  - S1100: 1->S1, 0->IDLE. This is non-overlapping; the next match needs a full new 1100.
- Hit rule:
  - det_hit=1 exactly when the granted channel's next state is S1100.
  - Latency is 1 cycle: grant in cycle N gives det_vld/det_ch/det_hit in cycle N+1.
  - det_vld=0 in any cycle following no grant, and det_hit is 0 then.
- Counter:
  - Increments by 1 on each hit of its channel.
  - Saturates at 2^CW-1 and does not wrap.
- Clear:
  - When clr_ch_vld=1, channel clr_ch's state is set to IDLE and its counter to 0 at the next edge.
  - The cleared channel is masked from arbitration that cycle (bit_rdy stays 0 for it); the grant passes to the next eligible channel.
  - clr_ch >= NCH is ignored.
- State isolation: channel states are fully independent; interleaving never corrupts another channel's progress.
- Non-granted channels' states and counters hold.
- rd_cnt:
  - Reflects register contents, not same-cycle updates.
  - rd_ch >= NCH returns 0.
- Reset mid-sequence discards all partial progress, counters and any pending det_vld.

Decomposition:
- Package seq1100_pkg holds:
  - the state encoding constants: IDLE=3'd0, S1=3'd1, S11=3'd2, S110=3'd3, S1100=3'd4;
  - a function next_state(state, bit);
  - a function is_hit(next) for next==S1100.
- Sub-module rr_arbiter (NCH, with mask and ptr) produces the one-hot grant and the grant index.
- The top level holds the state array, counters, clear logic and output registers.

Test Plan:
- Ch0 only, bits 1,1,0,0 -> det_hit=1 one cycle after the 4th bit; det_ch=0; rd_cnt(ch0)=1.
- Ch0 bits 1,1,1,0,0 then 1,0,0 -> one hit at the 5th bit, no hit at the 8th (S1100 + 1 goes to S1, then 0 goes to IDLE); count=1.
- All 4 channels valid every cycle, en=1 -> grants 0,1,2,3,0,1 in order; each channel fed 1,1,0,0 -> hits on ch0..ch3 in cycles 14..17 (grants in cycles 13..16); each count=1.
- Ch1 at S110 with clr_ch_vld=1, clr_ch=1 and bit_vld[1]=1 in the same cycle -> bit_rdy[1]=0, state goes to IDLE, count goes to 0; a following 0 gives no hit.
- CW=2, ch2 fed 1100 five times -> rd_cnt(ch2) reads 1,2,3,3,3 and never wraps.
- rst asserted after ch0 has seen 1,1,0 -> det_vld=0 and counts=0; a following single 0 gives no hit, and a full 1,1,0,0 then hits.
